// File: rtl/ft_rx_deframer_if.sv
// Payload byte stream leaving the deframer: valid/ready handshake with an end-of-frame marker.
interface ft_rx_deframer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/ft_rx_deframer.sv
// Hunts SOF/LEN/payload/CHK frames in the host byte stream read from the proto245a RX FIFO,
// streams the payload out and reports per-frame status with a saturating error counter.
module ft_rx_deframer #(
    parameter logic [7:0]  SOF            = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             ft_clk,
    input  logic             ft_rst,
    output logic             rxfifo_rd,
    input  logic [7:0]       rxfifo_data,
    input  logic             rxfifo_valid,
    input  logic             rxfifo_empty,
    ft_rx_deframer_if.master m_if,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {StHunt, StLen, StPayload, StChk} state_e;

    localparam logic [15:0] ToLast = 16'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             rd_q, rd_d;
    logic             pending_q, pending_d;
    logic             hold_valid_q, hold_valid_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       remaining_q, remaining_d;
    logic [7:0]       sum_q, sum_d;
    logic [15:0]      to_q, to_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             consume;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        sum_d        = sum_q;
        ok_d         = 1'b0;
        err_d        = 1'b0;
        code_d       = code_q;
        cnt_d        = cnt_q;
        consume      = 1'b0;
        to_d         = to_q;
        m_if.m_data  = 8'h00;
        m_if.m_valid = 1'b0;
        m_if.m_last  = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (hold_valid_q) begin
                    consume = 1'b1;
                    if (hold_q == SOF) state_d = StLen;
                end
            end
            StLen: begin
                if (hold_valid_q) begin
                    consume = 1'b1;
                    if (hold_q == 8'h00) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = StHunt;
                    end else begin
                        remaining_d = hold_q;
                        sum_d       = hold_q;
                        state_d     = StPayload;
                    end
                end
            end
            StPayload: begin
                m_if.m_valid = hold_valid_q;
                m_if.m_data  = hold_valid_q ? hold_q : 8'h00;
                m_if.m_last  = hold_valid_q && (remaining_q == 8'd1);
                if (hold_valid_q && m_if.m_ready) begin
                    consume     = 1'b1;
                    sum_d       = sum_q + hold_q;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) state_d = StChk;
                end
            end
            StChk: begin
                if (hold_valid_q) begin
                    consume = 1'b1;
                    state_d = StHunt;
                    if (hold_q == sum_q) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd2;
                    end
                end
            end
        endcase

        // Only host starvation counts; a full hold register (backpressure) freezes the counter.
        if (state_q == StHunt || consume) begin
            to_d = 16'd0;
        end else if (!hold_valid_q) begin
            if (to_q == ToLast) begin
                to_d    = 16'd0;
                err_d   = 1'b1;
                code_d  = 2'd3;
                state_d = StHunt;
            end else begin
                to_d = to_q + 16'd1;
            end
        end

        if (err_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    // Read engine: one outstanding read, one-byte hold register.
    always_comb begin
        rd_d         = !rxfifo_empty && !pending_q && !hold_valid_q;
        pending_d    = pending_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (rxfifo_valid && pending_q) begin
            pending_d    = 1'b0;
            hold_d       = rxfifo_data;
            hold_valid_d = 1'b1;
        end else if (consume) begin
            hold_valid_d = 1'b0;
        end
        if (rd_d) pending_d = 1'b1;
    end

    always_ff @(posedge ft_clk or negedge ft_rst) begin
        if (!ft_rst) begin
            state_q      <= StHunt;
            rd_q         <= 1'b0;
            pending_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= 8'h00;
            remaining_q  <= 8'h00;
            sum_q        <= 8'h00;
            to_q         <= 16'd0;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= 2'd0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            pending_q    <= pending_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            remaining_q  <= remaining_d;
            sum_q        <= sum_d;
            to_q         <= to_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rxfifo_rd = rd_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;
    assign err_cnt   = cnt_q;

endmodule

// File: doc/ft_rx_deframer.md
Name: ft_rx_deframer

Overview:
- Sits directly downstream of the proto245a receive FIFO and consumes bytes through its rxfifo_rd/rxfifo_data/rxfifo_valid/rxfifo_empty read port.
- Hunts for framed packets (SOF, LEN, payload, CHK) in the raw host byte stream.
- Emits each payload as a valid/ready byte stream with an end-of-frame marker.
- Reports per-frame pass/fail status plus an error counter to the user logic.

Parameters:
- SOF, 8'hA5, start-of-frame byte value.
- TIMEOUT_CYCLES, 1024, maximum idle cycles while waiting for a host byte mid-frame before the frame is aborted; legal range 2..65535.
- CNT_W, 16, width of err_cnt.

Ports:
- ft_clk  in  1  clock; same clock as the proto245a receive FIFO read side.
- ft_rst  in  1  reset, asynchronous, active-low.
- rxfifo_rd  out  1  read strobe to the RX FIFO.
- rxfifo_data  in  8  RX FIFO read data.
- rxfifo_valid  in  1  rxfifo_data valid this cycle.
- rxfifo_empty  in  1  RX FIFO empty.
- m_data  out  8  payload byte.
- m_valid  out  1  m_data valid.
- m_last  out  1  final payload byte of the frame; qualified by m_valid.
- m_ready  in  1  downstream accepts the byte.
- frame_ok  out  1  one-cycle pulse: frame complete and checksum good.
- frame_err  out  1  one-cycle pulse: frame aborted or checksum bad.
- err_code  out  2  cause of the last error: 1 = zero length, 2 = checksum, 3 = timeout. Held until the next error.
- err_cnt  out  CNT_W  saturating count of frame_err pulses.

Behaviour:
- Reset (ft_rst = 0, asynchronous): state HUNT; pending, hold_valid and timeout counter cleared.
  - All outputs are 0: rxfifo_rd, m_data, m_valid, m_last, frame_ok, frame_err, err_code, err_cnt.
  - Reset mid-frame discards the partial frame with no status pulse.
- Read engine:
  - The block keeps a one-byte hold register and a pending flag.
  - rxfifo_rd = !rxfifo_empty && !pending && !hold_valid, registered.
  - A read sets pending. rxfifo_valid loads the hold register and clears pending.
  - rxfifo_valid while pending = 0 is ignored.
  - Peak rate is one byte per two cycles.
- FSM states: HUNT, LEN, PAYLOAD, CHK. A byte is consumed from the hold register as follows:
  - HUNT: consumed immediately. If byte == SOF, go to LEN; otherwise drop it.
  - LEN: consumed immediately.
    - 0: frame_err, err_code = 1, go to HUNT.
    - Otherwise: remaining = len, sum = len, go to PAYLOAD.
  - PAYLOAD: hold register drives m_data with m_valid = 1. The byte is consumed only on m_valid && m_ready.
    - m_last = (remaining == 1).
    - On consume: sum += byte (mod 256) and remaining decrements.
    - After the last byte, go to CHK.
  - CHK: consumed immediately.
    - byte == sum: frame_ok pulse in the following cycle.
    - Otherwise: frame_err, err_code = 2.
    - Either way, go to HUNT.
- Backpressure: while m_ready = 0 the hold register stays full, so no further rxfifo_rd is issued. m_data, m_valid and m_last hold stable.
- Timeout:
  - The counter runs only in LEN, PAYLOAD and CHK, and only while hold_valid = 0 (waiting for the host).
  - It clears on every consumed byte and in HUNT.
  - On reaching TIMEOUT_CYCLES: frame_err, err_code = 3, go to HUNT.
  - A timeout abort in PAYLOAD produces no m_last; the consumer must treat frame_err as the terminator.
  - Backpressure never causes a timeout.
- Status pulses are registered and appear 1 cycle after the triggering byte is consumed; frame_ok and frame_err are never both high.
- err_cnt increments on each frame_err and saturates at 2^CNT_W - 1.
- A SOF value inside LEN, payload or CHK is treated as data; no resynchronisation occurs mid-frame.

Test Plan:
- Bytes A5 03 11 22 33 69 -> m_data 11, 22, 33 in order; m_last only with 33; one frame_ok; err_cnt = 0.
- Bytes 00 FF A5 01 7E 7F -> 00 and FF dropped; single payload byte 7E with m_last; frame_ok.
- Bytes A5 02 10 20 00 -> 10 and 20 delivered with m_last on 20; frame_err with err_code = 2; err_cnt = 1.
- Bytes A5 00, then A5 01 55 56 -> frame_err with err_code = 1; the following frame delivers 55 and gives frame_ok; err_cnt = 1.
- Frame A5 04 01 02 03 04 0E with m_ready held low for 40 cycles after byte 02 -> rxfifo_rd stays low during the stall; no timeout even with TIMEOUT_CYCLES = 16; order preserved; frame_ok.
- TIMEOUT_CYCLES = 64, bytes A5 04 11 then FIFO empty -> frame_err with err_code = 3 exactly 64 idle cycles after 11 is consumed; no m_last. Separately, pull ft_rst low mid-frame -> all outputs 0 immediately and the next frame decodes cleanly.
